pipe_hazard_ctrl: RTL

//   Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.

---
 rtl/pipe_hazard_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: tracks a tag for every stage after ID and derives the
// load-use stall, the branch flush and the EX forwarding selects from those tags.
module pipe_hazard_ctrl #(
    parameter int REG_W          = 5,
    parameter int EX_DEPTH       = 3,
    parameter int BRANCH_STAGE   = 2,
    parameter int LOAD_FWD_STAGE = 3,
    parameter int CNT_W          = 16,
    localparam int FWD_W         = $clog2(EX_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             br_taken,
    output logic             stall,
    output logic             flush,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
        logic             reg_write;
        logic             mem_read;
    } tag_t;

    tag_t slot [1:EX_DEPTH];
    tag_t id_tag;
    logic load_hazard;

    // Writes to x0 are discarded by the register file, so they never hazard or forward.
    function automatic logic is_writer(tag_t t);
        return t.valid && t.reg_write && (t.rd != '0);
    endfunction

    always_comb begin
        id_tag = '{valid: id_valid, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                   use_rs1: id_use_rs1, use_rs2: id_use_rs2,
                   reg_write: id_reg_write, mem_read: id_mem_read};

        flush = br_taken && slot[BRANCH_STAGE].valid;

        // Only loads younger than the first stage that can forward load data must hold ID.
        load_hazard = 1'b0;
        for (int s = 1; s < LOAD_FWD_STAGE - 1; s++) begin
            if (is_writer(slot[s]) && slot[s].mem_read &&
                ((id_use_rs1 && (id_rs1 == slot[s].rd)) ||
                 (id_use_rs2 && (id_rs2 == slot[s].rd))))
                load_hazard = 1'b1;
        end
        stall = !flush && id_valid && load_hazard;

        // Scan oldest to youngest so the youngest matching writer overrides older ones.
        fwd_a = '0;
        fwd_b = '0;
        if (slot[1].valid) begin
            for (int k = EX_DEPTH; k >= 2; k--) begin
                if (is_writer(slot[k]) && slot[1].use_rs1 && (slot[k].rd == slot[1].rs1))
                    fwd_a = FWD_W'(k - 1);
                if (is_writer(slot[k]) && slot[1].use_rs2 && (slot[k].rd == slot[1].rs2))
                    fwd_b = FWD_W'(k - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= EX_DEPTH; k++)
                slot[k] <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            slot[1] <= (id_valid && !stall && !flush) ? id_tag : '0;
            // Instructions younger than the resolving branch are squashed as they advance.
            for (int k = 1; k < EX_DEPTH; k++)
                slot[k+1] <= (flush && (k < BRANCH_STAGE)) ? '0 : slot[k];
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
